// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the quadrature encoder emulator.
//   enc_state_e : sequencer state (IDLE, RUN, DONE)
//   AB_IDLE     : resting level of the A/B pair (both high)
//   quad_ab()   : quadrature Gray table, phase 0..3 -> {A,B} for a direction
// ---------------------------------------------------------------------------
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_e;

    localparam logic [1:0] AB_IDLE = 2'b11;

    // dir=0: A leads  11 -> 01 -> 00 -> 10 -> 11
    // dir=1: B leads  11 -> 10 -> 00 -> 01 -> 11
    // Adjacent phases differ in exactly one bit in both directions.
    function automatic logic [1:0] quad_ab(input logic b_leads, input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b11;
            2'd1:    ab = b_leads ? 2'b10 : 2'b01;
            2'd2:    ab = 2'b00;
            default: ab = b_leads ? 2'b01 : 2'b10;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/enc_phase_tick.sv
// ---------------------------------------------------------------------------
// enc_phase_tick
// Phase-rate divider: counts 0..CLK_DIV-1 while enabled and emits a one-cycle
// tick on the terminal count, then wraps to 0.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (counter -> 0)
//   en   in  count enable
//   clr  in  synchronous clear (counter -> 0), used whenever not running
//   tick out high for one cycle when the counter sits at CLK_DIV-1 with en=1
// ---------------------------------------------------------------------------
module enc_phase_tick #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/enc_quad_gen.sv
// ---------------------------------------------------------------------------
// enc_quad_gen
// Rotary-encoder emulator: emits 'steps' full quadrature cycles on A/B in the
// commanded direction. Each step is four Gray-code edges spaced CLK_DIV clocks
// apart, starting and ending at A=B=1.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   command strobe (taken only while idle)
//   dir        in   0: A leads, 1: B leads (sampled with start)
//   steps      in   step count (sampled with start)
//   stop       in   abort request; the step in progress is finished first
//   A, B       out  quadrature outputs, registered, idle high
//   busy       out  high while a sequence is running
//   done       out  one-cycle pulse when a sequence ends
//   remaining  out  steps still to emit, including the one in progress
// Handshake: a command is accepted on the clock edge where start=1 and the
// sequencer is idle (busy=0, no done pending); start at any other time is
// dropped, and dir/steps are only looked at on that accepting edge.
// ---------------------------------------------------------------------------
module enc_quad_gen
    import enc_pkg::*;
#(
    parameter int CLK_DIV = 250,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic             stop,
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    enc_state_e state;
    logic [1:0] phase;
    logic       dir_q;
    logic       stop_q;
    logic       tick;
    logic [1:0] next_phase;
    logic       last_step;

    enc_phase_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state == RUN),
        .clr (state != RUN),
        .tick(tick)
    );

    assign next_phase = phase + 2'd1;
    // A stop seen on the boundary edge itself still ends the sequence there.
    assign last_step  = (remaining == CNT_W'(1)) || stop_q || stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= 2'd0;
            dir_q     <= 1'b0;
            stop_q    <= 1'b0;
            {A, B}    <= AB_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    stop_q <= 1'b0;
                    if (start) begin
                        dir_q     <= dir;
                        remaining <= steps;
                        phase     <= 2'd0;
                        {A, B}    <= AB_IDLE;
                        if (steps != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (tick) begin
                        phase  <= next_phase;
                        {A, B} <= quad_ab(dir_q, next_phase);
                        // Phase 3 -> 0 returns A/B to 11 and closes a step.
                        if (phase == 2'd3) begin
                            if (remaining != '0) begin
                                remaining <= remaining - 1'b1;
                            end
                            if (last_step) begin
                                state  <= DONE;
                                busy   <= 1'b0;
                                stop_q <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
